// File: rtl/fazyrv_deser.sv
// -----------------------------------------------------------------------------
// fazyrv_deser
// Chunk-to-word deserializer. Collects N = 32/BWIDTH chunks (least significant
// chunk first) into a 32-bit word and hands the word to a consumer with a
// valid/ready handshake. While a finished word waits for the consumer, the
// input side is stalled. When the consumer takes the word and a chunk is
// offered in the same cycle, that chunk already starts the next word, so there
// is no bubble between back-to-back words.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_in     : synchronous reset, active low
//   clr_i      : drop the partial/held word (state and count only)
//   vld_i      : chunk on dat_i is valid
//   dat_i      : incoming chunk, BWIDTH bits
//   rdy_o      : chunk is taken when vld_i & rdy_o
//   wrd_vld_o  : assembled word available on wrd_o
//   wrd_o      : assembled word (meaningful only while wrd_vld_o = 1)
//   wrd_rdy_i  : consumer takes the word when wrd_vld_o & wrd_rdy_i
//   cnt_o      : chunks held in the current partial word
// -----------------------------------------------------------------------------
module fazyrv_deser #(
    parameter int BWIDTH = 1,
    localparam int N  = 32 / BWIDTH,
    localparam int CW = $clog2(N) + 1
) (
    input  logic              clk_i,
    input  logic              rst_in,
    input  logic              clr_i,
    input  logic              vld_i,
    input  logic [BWIDTH-1:0] dat_i,
    output logic              rdy_o,
    output logic              wrd_vld_o,
    output logic [31:0]       wrd_o,
    input  logic              wrd_rdy_i,
    output logic [CW-1:0]     cnt_o
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t          state_q;
    logic [31:0]     shreg_q;
    logic [31:0]     shreg_d;
    logic [CW-1:0]   cnt_q;
    logic            accept;

    // New chunks enter at the top, so after N shifts the first chunk sits in
    // the lowest BWIDTH bits.
    assign shreg_d = {dat_i, shreg_q[31:BWIDTH]};

    // In FULL the input side may only move when the held word leaves in the
    // same cycle; reset and clear always block acceptance.
    assign rdy_o  = rst_in & ~clr_i & ((state_q == FILL) | wrd_rdy_i);
    assign accept = vld_i & rdy_o;

    assign wrd_vld_o = (state_q == FULL);
    assign wrd_o     = shreg_q;
    assign cnt_o     = cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state_q <= FILL;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else if (clr_i) begin
            // Abort: shift register contents are intentionally left alone.
            state_q <= FILL;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        shreg_q <= shreg_d;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= FULL;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                FULL: begin
                    if (wrd_rdy_i) begin
                        state_q <= FILL;
                        if (vld_i) begin
                            // Word leaves and the next word's first chunk
                            // arrives in the same cycle.
                            shreg_q <= shreg_d;
                            cnt_q   <= CNT_ONE;
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= FILL;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
